// File: rtl/bus_arbiter.sv
// Round-robin arbiter and transfer sequencer for the shared internal data bus.
// Registers one grant per cycle, with a bounded locked burst, and drives the bus and load strobes.
module bus_arbiter #(
    parameter int unsigned REQ_COUNT  = 4,
    parameter int unsigned DEST_COUNT = 8,
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned LOCK_MAX   = 4,
    parameter int unsigned DEST_SEL_W = $clog2(DEST_COUNT)
) (
    input  logic                             clk,
    input  logic                             nrst,
    input  logic [REQ_COUNT-1:0]             req_i,
    input  logic [REQ_COUNT-1:0]             req_lock_i,
    input  logic [REQ_COUNT*WIDTH-1:0]       req_data_i,
    input  logic [REQ_COUNT*DEST_SEL_W-1:0]  req_dest_i,
    output logic [REQ_COUNT-1:0]             grant_o,
    output logic [WIDTH-1:0]                 bus_data_o,
    output logic [DEST_COUNT-1:0]            dest_load_enable_o,
    output logic                             busy_o
);

    localparam int unsigned PtrW = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;
    localparam int unsigned CntW = $clog2(LOCK_MAX + 1);
    localparam logic [PtrW-1:0] PtrRst = PtrW'(REQ_COUNT - 1);

    typedef enum logic [1:0] {StIdle, StGrant, StLocked} state_e;

    state_e                 state_q, state_d;
    logic [PtrW-1:0]        ptr_q, ptr_d;
    logic [CntW-1:0]        lock_cnt_q, lock_cnt_d;
    logic [REQ_COUNT-1:0]   grant_q, grant_d;
    logic [WIDTH-1:0]       bus_data_q, bus_data_d;
    logic [DEST_COUNT-1:0]  dle_q, dle_d;
    logic                   busy_q, busy_d;

    logic [REQ_COUNT-1:0]   holder_oh;
    logic [REQ_COUNT-1:0]   cand;
    logic                   cont;
    logic                   found;
    logic                   issue;
    logic [PtrW-1:0]        pick;
    logic [PtrW-1:0]        win;
    logic [DEST_SEL_W-1:0]  win_dest;
    int unsigned            idx;

    always_comb begin
        holder_oh = '0;
        holder_oh[ptr_q] = (state_q != StIdle);
        // Holder keeps the bus only while its lock budget lasts.
        cont = (state_q != StIdle) && req_i[ptr_q] && req_lock_i[ptr_q] &&
               (32'(lock_cnt_q) < LOCK_MAX - 1);
        cand = req_i & ~holder_oh;

        found = 1'b0;
        pick  = ptr_q;
        idx   = 0;
        for (int unsigned off = 1; off <= REQ_COUNT; off++) begin
            idx = (32'(ptr_q) + off) % REQ_COUNT;
            if (!found && cand[idx[PtrW-1:0]]) begin
                found = 1'b1;
                pick  = idx[PtrW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_cnt_d = lock_cnt_q;
        grant_d    = '0;
        bus_data_d = bus_data_q;
        dle_d      = '0;
        win        = ptr_q;
        issue      = 1'b0;
        win_dest   = '0;

        if (cont) begin
            state_d    = StLocked;
            lock_cnt_d = lock_cnt_q + CntW'(1);
            issue      = 1'b1;
        end else if (found) begin
            state_d    = StGrant;
            ptr_d      = pick;
            lock_cnt_d = '0;
            win        = pick;
            issue      = 1'b1;
        end else begin
            state_d    = StIdle;
            lock_cnt_d = '0;
        end

        if (issue) begin
            grant_d[win] = 1'b1;
            bus_data_d   = req_data_i[32'(win)*WIDTH +: WIDTH];
            win_dest     = req_dest_i[32'(win)*DEST_SEL_W +: DEST_SEL_W];
            // Indices past DEST_COUNT match no bit, so the beat is dropped.
            for (int unsigned d = 0; d < DEST_COUNT; d++) begin
                dle_d[d] = (win_dest == DEST_SEL_W'(d));
            end
        end
        busy_d = issue;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= StIdle;
            ptr_q      <= PtrRst;
            lock_cnt_q <= '0;
            grant_q    <= '0;
            bus_data_q <= '0;
            dle_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lock_cnt_q <= lock_cnt_d;
            grant_q    <= grant_d;
            bus_data_q <= bus_data_d;
            dle_q      <= dle_d;
            busy_q     <= busy_d;
        end
    end

    assign grant_o            = grant_q;
    assign bus_data_o         = bus_data_q;
    assign dest_load_enable_o = dle_q;
    assign busy_o             = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: vector table plus hand sequences for reset corners.
// DEST_COUNT=6 so a 3-bit index of 7 exercises the dropped-transfer case.
module tb_bus_arbiter;

    localparam int unsigned RC = 4;
    localparam int unsigned DC = 6;
    localparam int unsigned W  = 8;
    localparam int unsigned LM = 4;
    localparam int unsigned DW = 3;

    typedef struct {
        logic [RC-1:0]    req;
        logic [RC-1:0]    lock;
        logic [RC*W-1:0]  data;
        logic [RC*DW-1:0] dest;
        logic [RC-1:0]    exp_grant;
        logic [W-1:0]     exp_data;
        logic [DC-1:0]    exp_dle;
    } vec_t;

    logic             clk;
    logic             nrst;
    logic [RC-1:0]    req;
    logic [RC-1:0]    req_lock;
    logic [RC*W-1:0]  req_data;
    logic [RC*DW-1:0] req_dest;
    logic [RC-1:0]    grant;
    logic [W-1:0]     bus_data;
    logic [DC-1:0]    dle;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;
    vec_t vecs[$];

    bus_arbiter #(
        .REQ_COUNT (RC),
        .DEST_COUNT(DC),
        .WIDTH     (W),
        .LOCK_MAX  (LM),
        .DEST_SEL_W(DW)
    ) dut (
        .clk               (clk),
        .nrst              (nrst),
        .req_i             (req),
        .req_lock_i        (req_lock),
        .req_data_i        (req_data),
        .req_dest_i        (req_dest),
        .grant_o           (grant),
        .bus_data_o        (bus_data),
        .dest_load_enable_o(dle),
        .busy_o            (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [RC-1:0] g, input logic [W-1:0] d,
                             input logic [DC-1:0] e);
        check({tag, ".grant"}, 32'(grant), 32'(g));
        check({tag, ".busData"}, 32'(bus_data), 32'(d));
        check({tag, ".destLoadEnable"}, 32'(dle), 32'(e));
        check({tag, ".busy"}, 32'(busy), 32'(|g));
    endtask

    task automatic add(input logic [RC-1:0] r, input logic [RC-1:0] l, input logic [RC*W-1:0] da,
                       input logic [RC*DW-1:0] de, input logic [RC-1:0] g, input logic [W-1:0] d,
                       input logic [DC-1:0] e);
        vec_t v;
        v.req = r; v.lock = l; v.data = da; v.dest = de;
        v.exp_grant = g; v.exp_data = d; v.exp_dle = e;
        vecs.push_back(v);
    endtask

    initial begin
        // Round robin from reset pointer: data 10..13, dests 0..3.
        add(4'hF, 4'h0, 32'h13121110, 12'h688, 4'b0001, 8'h10, 6'b000001);
        add(4'hF, 4'h0, 32'h13121110, 12'h688, 4'b0010, 8'h11, 6'b000010);
        add(4'hF, 4'h0, 32'h13121110, 12'h688, 4'b0100, 8'h12, 6'b000100);
        add(4'hF, 4'h0, 32'h13121110, 12'h688, 4'b1000, 8'h13, 6'b001000);
        add(4'hF, 4'h0, 32'h13121110, 12'h688, 4'b0001, 8'h10, 6'b000001);
        // Single request held: grant, gap, grant.
        add(4'h4, 4'h0, 32'h00A50000, 12'h0C0, 4'b0100, 8'hA5, 6'b001000);
        add(4'h4, 4'h0, 32'h00A50000, 12'h0C0, 4'b0000, 8'hA5, 6'b000000);
        add(4'h4, 4'h0, 32'h00A50000, 12'h0C0, 4'b0100, 8'hA5, 6'b001000);
        // Out-of-range destination 7: grant issued, no strobe.
        add(4'h2, 4'h0, 32'h00005A00, 12'h038, 4'b0010, 8'h5A, 6'b000000);
        add(4'h0, 4'h0, 32'h00005A00, 12'h038, 4'b0000, 8'h5A, 6'b000000);
        // Locked burst of LOCK_MAX beats, then requester 1, then 0 resumes.
        add(4'h3, 4'h1, 32'h00007711, 12'h008, 4'b0001, 8'h11, 6'b000001);
        add(4'h3, 4'h1, 32'h00007722, 12'h008, 4'b0001, 8'h22, 6'b000001);
        add(4'h3, 4'h1, 32'h00007733, 12'h008, 4'b0001, 8'h33, 6'b000001);
        add(4'h3, 4'h1, 32'h00007744, 12'h008, 4'b0001, 8'h44, 6'b000001);
        add(4'h3, 4'h1, 32'h00007755, 12'h008, 4'b0010, 8'h77, 6'b000010);
        add(4'h3, 4'h1, 32'h00007755, 12'h008, 4'b0001, 8'h55, 6'b000001);
        add(4'h0, 4'h0, 32'h00007755, 12'h008, 4'b0000, 8'h55, 6'b000000);
        // Sole locked requester: exhausted lock forces one idle cycle.
        add(4'h1, 4'h1, 32'h00000066, 12'h000, 4'b0001, 8'h66, 6'b000001);
        add(4'h1, 4'h1, 32'h00000066, 12'h000, 4'b0001, 8'h66, 6'b000001);
        add(4'h1, 4'h1, 32'h00000066, 12'h000, 4'b0001, 8'h66, 6'b000001);
        add(4'h1, 4'h1, 32'h00000066, 12'h000, 4'b0001, 8'h66, 6'b000001);
        add(4'h1, 4'h1, 32'h00000066, 12'h000, 4'b0000, 8'h66, 6'b000000);
        add(4'h1, 4'h1, 32'h00000066, 12'h000, 4'b0001, 8'h66, 6'b000001);
        add(4'h0, 4'h0, 32'h00000066, 12'h000, 4'b0000, 8'h66, 6'b000000);

        // Reset held with all requests high.
        nrst = 1'b0;
        req = 4'hF; req_lock = 4'h0; req_data = 32'h13121110; req_dest = 12'h688;
        @(negedge clk);
        @(negedge clk);
        check_all("reset", 4'b0000, 8'h00, 6'b000000);

        nrst = 1'b1;
        foreach (vecs[i]) begin
            req = vecs[i].req; req_lock = vecs[i].lock;
            req_data = vecs[i].data; req_dest = vecs[i].dest;
            @(negedge clk);
            check_all($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_data,
                      vecs[i].exp_dle);
        end

        // Reset during the third locked beat; pointer was left at requester 0.
        req = 4'h1; req_lock = 4'h1; req_data = 32'h00000011; req_dest = 12'h002;
        @(negedge clk);
        check_all("burst.b1", 4'b0001, 8'h11, 6'b000100);
        req_data = 32'h00000022;
        @(negedge clk);
        check_all("burst.b2", 4'b0001, 8'h22, 6'b000100);
        req_data = 32'h00000033;
        @(negedge clk);
        check_all("burst.b3", 4'b0001, 8'h33, 6'b000100);
        #2 nrst = 1'b0;
        #1 check_all("midreset", 4'b0000, 8'h00, 6'b000000);
        @(negedge clk);
        nrst = 1'b1;
        req = 4'hF; req_lock = 4'h0; req_data = 32'h13121110; req_dest = 12'h688;
        @(negedge clk);
        check_all("postreset", 4'b0001, 8'h10, 6'b000001);
        @(negedge clk);
        check_all("postreset2", 4'b0010, 8'h11, 6'b000010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter and transfer sequencer for the shared internal data bus. It accepts byte-transfer requests from up to REQ_COUNT sources, grants one source per cycle, and drives the bus value. It also drives the one-hot load-enable vector that feeds the destination registers' busReadEnable inputs. It supports locked multi-beat bursts with a bounded length, so no source can starve the others.

## Interface
- REQ_COUNT, 4: number of requesters (≥2)
- DEST_COUNT, 8: number of destination registers on the bus
- WIDTH, 8: bus width in bits
- LOCK_MAX, 4: maximum consecutive grants one requester may hold under lock (≥1)
- DEST_SEL_W, $clog2(DEST_COUNT): width of each destination index
- clk, input, 1: clock
- nrst, input, 1: reset, asynchronous, active-low
- req, input, REQ_COUNT: per-requester transfer request
- reqLock, input, REQ_COUNT: per-requester burst lock; continues the grant into the next cycle
- reqData, input, REQ_COUNT*WIDTH: packed data; requester i uses bits [WIDTH*(i+1)-1:WIDTH*i]
- reqDest, input, REQ_COUNT*DEST_SEL_W: packed destination index per requester, same packing
- grant, output, REQ_COUNT: one-hot grant (all zero when idle)
- busData, output, WIDTH: value on the bus during the grant cycle
- destLoadEnable, output, DEST_COUNT: one-hot load strobe to the destination register
- busy, output, 1: high in any cycle where grant is non-zero

## Operation
- All outputs are registered and update on posedge clk. Reset values: grant=0, busData=0, destLoadEnable=0, busy=0, priority pointer=REQ_COUNT-1 (requester 0 wins first), lock counter=0.
- States:
  - IDLE: no grant.
  - GRANT: single beat.
  - LOCKED: burst continuing.
- Arbitration runs at every edge. The candidate set is {i : req[i]=1}, minus the currently granted requester unless that requester is continuing a lock.
- Lock continuation happens when the current state is GRANT or LOCKED, the holder has req=1 and reqLock=1, and lockCount < LOCK_MAX-1. In that case the holder is re-granted, lockCount increments, and the state becomes LOCKED. Other requests are ignored.
- If continuation is not taken, the arbiter picks the first candidate at or after pointer+1, with modulo-REQ_COUNT wrap-around.
  - On a pick: the state goes to GRANT, the pointer is set to the winner, and lockCount is cleared to 0.
  - With no candidate: the state goes to IDLE and grant is cleared to 0.
- When a lock reaches LOCK_MAX grants, the holder is excluded from the next arbitration. If it is the only requester, one IDLE cycle results.
- At the edge that issues or continues a grant, the arbiter captures the winner's reqData into busData. It also decodes the winner's reqDest into destLoadEnable, setting bit reqDest.
- A reqDest ≥ DEST_COUNT yields destLoadEnable=0. The grant is still issued and consumed, so the transfer is dropped silently.
- When no grant is issued, busData holds its last value and destLoadEnable=0.
- Reset asserted mid-burst immediately forces the reset values. The first grant after reset follows the reset pointer.

## Timing
- Latency: req sampled high at edge k gives grant high during cycle k+1 (earliest one cycle after req rises).
- Handshake:
  - Requester i must hold req, reqData and reqDest stable until the edge at which it is granted.
  - A grant lasts exactly one cycle per beat.
  - A requester that sees grant[i] must drop req before the next edge unless it has another transfer. Even if req stays high, a non-locked requester is never granted in two consecutive cycles.
- Burst: during each cycle that grant[i] is high with reqLock[i]=1, requester i presents the next beat's reqData/reqDest. That beat is transferred in the following cycle.
- grant, busData and destLoadEnable are mutually consistent within a cycle. Destination registers latch busData at the edge that ends the grant cycle.
- Back-to-back grants to different requesters are allowed in consecutive cycles with no bubble.
- busy equals |grant, as a registered signal.

## Test plan
- Reset: hold nrst=0 with all reqs high → grant=0, busData=0, destLoadEnable=0, busy=0. Release → cycle 1 grant=0001.
- Single request: req=0100, reqData[2]=8'hA5, reqDest[2]=3 → one cycle later grant=0100, busData=A5, destLoadEnable=00001000. Keep req high → next cycle grant=0. The cycle after that, grant=0100 again.
- Round robin: req=1111 held, no locks → grant sequence 0001, 0010, 0100, 1000, 0001 with no idle cycles.
- Locked burst: LOCK_MAX=4, req=0011, reqLock[0]=1 held → grant 0001 ×4 with successive data 11, 22, 33, 44, then 0010, then 0001 resumes.
- Out-of-range destination: DEST_COUNT=6, reqDest=7 → grant issued for one cycle, destLoadEnable=0.
- Reset mid-burst: assert nrst=0 during the third locked beat → outputs zero asynchronously. After release, arbitration restarts at requester 0.
